slow_fpu_issue: RTL and testbench

Issue and writeback controller for multi-cycle FPU operations (fdiv, fsqrt, fmadd/fmsub/fnmsub/fnmadd).
- Sits in EX, directly downstream of the decoder's `slow_fpu_dispatch`.
- Latches operands, launches the fixed-latency slow FPU datapath, and counts its latency.
- Holds the result until the FPU register-file write port grants it.
- Publishes one combined stall (structural, RAW and WAW) back to the ID stage.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/slow_fpu_issue.sv | 133 +++++++++++++
 tb/tb_slow_fpu_issue.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the slow FPU issue/writeback path: op encoding and FSM states.
package fpu_pkg;

  typedef enum logic [2:0] {
    FMADD  = 3'd0,
    FMSUB  = 3'd1,
    FNMSUB = 3'd2,
    FNMADD = 3'd3,
    FDIV   = 3'd4,
    FSQRT  = 3'd5
  } slow_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } slow_fsm_t;

endpackage

// File: rtl/slow_fpu_issue.sv
// Issue/writeback controller for the multi-cycle FPU: latches one op, times the
// fixed-latency datapath, holds the result until the FP write port accepts it,
// and raises a combined structural/RAW/WAW stall towards ID.
module slow_fpu_issue
  import fpu_pkg::*;
#(
  parameter int FMA_LAT  = 6,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 10
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        dispatch_valid,
  input  slow_op_t    dispatch_op,
  input  logic [4:0]  dispatch_rd,
  input  logic [31:0] dispatch_a,
  input  logic [31:0] dispatch_b,
  input  logic [31:0] dispatch_c,
  output logic        dispatch_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rs3,
  input  logic [2:0]  id_use,
  input  logic [4:0]  id_rd,
  input  logic        id_fp_write,
  input  logic        id_slow,
  output logic        stall,
  output logic        fu_start,
  output slow_op_t    fu_op,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic [31:0] fu_c,
  input  logic [31:0] fu_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic        wb_ack
);

  localparam int MAX_AB  = (FMA_LAT > DIV_LAT) ? FMA_LAT : DIV_LAT;
  localparam int MAX_LAT = (MAX_AB > SQRT_LAT) ? MAX_AB : SQRT_LAT;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

  // Reserved encodings 110/111 are timed like fdiv.
  function automatic logic [CNT_W-1:0] op_lat(input slow_op_t op);
    case (op)
      FMADD, FMSUB, FNMSUB, FNMADD: op_lat = CNT_W'(FMA_LAT);
      FSQRT:                        op_lat = CNT_W'(SQRT_LAT);
      default:                      op_lat = CNT_W'(DIV_LAT);
    endcase
  endfunction

  slow_fsm_t        state;
  slow_fsm_t        state_d;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             raw_hz;
  logic             waw_hz;
  logic             struct_hz;

  assign dispatch_ready = (state == S_IDLE);

  // Hazards against the single in-flight destination; no forwarding from wb_data.
  assign struct_hz = id_slow & (state != S_IDLE);
  assign raw_hz    = pending & ((id_use[0] & (id_rs1 == wb_rd)) |
                                (id_use[1] & (id_rs2 == wb_rd)) |
                                (id_use[2] & (id_rs3 == wb_rd)));
  assign waw_hz    = pending & id_fp_write & (id_rd == wb_rd);
  assign stall     = struct_hz | raw_hz | waw_hz;

  // Next-state logic: accept only in IDLE, leave EXEC when the count expires,
  // leave WB only on a write-port grant.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (dispatch_valid) state_d = S_EXEC;
      S_EXEC:  if (cnt == '0)      state_d = S_WB;
      S_WB:    if (wb_ack)         state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus operand/result latches; reset clears everything so an
  // in-flight result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pending  <= 1'b0;
      fu_start <= 1'b0;
      fu_op    <= FMADD;
      fu_a     <= '0;
      fu_b     <= '0;
      fu_c     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      state    <= state_d;
      fu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dispatch_valid) begin
            fu_op    <= dispatch_op;
            fu_a     <= dispatch_a;
            fu_b     <= dispatch_b;
            fu_c     <= dispatch_c;
            wb_rd    <= dispatch_rd;
            cnt      <= op_lat(dispatch_op);
            pending  <= 1'b1;
            fu_start <= 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            wb_data  <= fu_result;
            wb_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_WB: begin
          if (wb_ack) begin
            pending  <= 1'b0;
            wb_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slow_fpu_issue.sv
// Self-checking bench for slow_fpu_issue: directed scenarios plus randomized
// transactions checked against a cycle-timeline reference model.
module tb_slow_fpu_issue;
  import fpu_pkg::*;

  localparam int T_FMA  = 6;
  localparam int T_DIV  = 12;
  localparam int T_SQRT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dispatch_valid = 1'b0;
  logic        dispatch_valid_m = 1'b0;
  slow_op_t    dispatch_op = FMADD;
  logic [4:0]  dispatch_rd = '0;
  logic [31:0] dispatch_a = '0, dispatch_b = '0, dispatch_c = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rs3 = '0, id_rd = '0;
  logic [2:0]  id_use = '0;
  logic        id_fp_write = 1'b0, id_slow = 1'b0;
  logic [31:0] fu_result = '0;
  logic        wb_ack = 1'b0;
  logic        wb_ack_m = 1'b1;

  logic        dispatch_ready, stall, fu_start, wb_valid;
  slow_op_t    fu_op;
  logic [31:0] fu_a, fu_b, fu_c, wb_data;
  logic [4:0]  wb_rd;

  logic        dispatch_ready_m, stall_m, fu_start_m, wb_valid_m;
  slow_op_t    fu_op_m;
  logic [31:0] fu_a_m, fu_b_m, fu_c_m, wb_data_m;
  logic [4:0]  wb_rd_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slow_fpu_issue #(.FMA_LAT(T_FMA), .DIV_LAT(T_DIV), .SQRT_LAT(T_SQRT)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op), .dispatch_rd(dispatch_rd),
    .dispatch_a(dispatch_a), .dispatch_b(dispatch_b), .dispatch_c(dispatch_c),
    .dispatch_ready(dispatch_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3), .id_use(id_use),
    .id_rd(id_rd), .id_fp_write(id_fp_write), .id_slow(id_slow),
    .stall(stall), .fu_start(fu_start), .fu_op(fu_op),
    .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c), .fu_result(fu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ack(wb_ack)
  );

  slow_fpu_issue #(.FMA_LAT(1), .DIV_LAT(T_DIV), .SQRT_LAT(T_SQRT)) dut_min (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid_m), .dispatch_op(dispatch_op), .dispatch_rd(dispatch_rd),
    .dispatch_a(dispatch_a), .dispatch_b(dispatch_b), .dispatch_c(dispatch_c),
    .dispatch_ready(dispatch_ready_m),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3), .id_use(id_use),
    .id_rd(id_rd), .id_fp_write(id_fp_write), .id_slow(id_slow),
    .stall(stall_m), .fu_start(fu_start_m), .fu_op(fu_op_m),
    .fu_a(fu_a_m), .fu_b(fu_b_m), .fu_c(fu_c_m), .fu_result(fu_result),
    .wb_valid(wb_valid_m), .wb_rd(wb_rd_m), .wb_data(wb_data_m), .wb_ack(wb_ack_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Dispatch must never arrive while the block is busy.
  always @(negedge clk) begin
    if (dispatch_valid)   chk("protocol_main", 32'(dispatch_ready), 32'd1);
    if (dispatch_valid_m) chk("protocol_min", 32'(dispatch_ready_m), 32'd1);
  end

  function automatic int lat_of(input logic [2:0] op);
    if (op <= 3'd3)      return T_FMA;
    else if (op == 3'd5) return T_SQRT;
    else                 return T_DIV;
  endfunction

  // Stall as the hazard rules define it, given whether the unit is busy and
  // whether a destination is outstanding.
  function automatic logic model_stall(input logic busy, input logic pend, input logic [4:0] rd);
    logic raw, waw;
    raw = (id_use[0] && id_rs1 == rd) || (id_use[1] && id_rs2 == rd) ||
          (id_use[2] && id_rs3 == rd);
    waw = id_fp_write && (id_rd == rd);
    return (busy && id_slow) || (pend && (raw || waw));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick(input logic [4:0] rd);
    return ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
  endfunction

  task automatic drive_id(input int mode, input int k, input logic [4:0] rd);
    case (mode)
      1: begin
        id_rs1 = rd; id_rs2 = rd + 5'd1; id_rs3 = rd + 5'd2; id_use = 3'b001;
        id_rd = rd + 5'd3; id_fp_write = 1'b1; id_slow = 1'b0;
      end
      2: begin
        id_rs1 = rd + 5'd1; id_rs2 = rd + 5'd2; id_rs3 = rd + 5'd3;
        id_rd = rd + 5'd4; id_use = 3'b000; id_fp_write = 1'b0; id_slow = 1'b0;
        case (k % 4)
          0: begin id_rs2 = rd; id_use = 3'b010; id_fp_write = 1'b1; end
          1: begin id_rs2 = rd; id_use = 3'b000; id_rd = rd; end
          2: begin id_rd = rd; id_fp_write = 1'b1; end
          default: begin id_slow = 1'b1; id_use = 3'b111; id_fp_write = 1'b1; end
        endcase
      end
      default: begin
        id_rs1 = pick(rd); id_rs2 = pick(rd); id_rs3 = pick(rd); id_rd = pick(rd);
        id_use = 3'($urandom); id_fp_write = 1'($urandom);
        id_slow = ($urandom_range(0, 3) == 0);
      end
    endcase
  endtask

  // One transaction on the main instance: accept, then walk the expected
  // timeline cycle by cycle. The datapath result is presented only in the
  // single cycle where it is due; every other cycle carries junk.
  task automatic run_op(input logic [2:0] op, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] res, input int ack_delay, input int mode);
    int lat;
    int last;
    lat  = lat_of(op);
    last = 2 + lat + ack_delay;
    chk("ready_pre", 32'(dispatch_ready), 32'd1);
    dispatch_op = slow_op_t'(op); dispatch_rd = rd;
    dispatch_a = a; dispatch_b = b; dispatch_c = c;
    dispatch_valid = 1'b1;
    tick();
    dispatch_valid = 1'b0;
    dispatch_op = slow_op_t'(3'($urandom)); dispatch_rd = 5'($urandom);
    dispatch_a = $urandom; dispatch_b = $urandom; dispatch_c = $urandom;
    for (int k = 1; k <= last; k++) begin
      fu_result = (k == 1 + lat) ? res : $urandom;
      if (k < 2 + lat) wb_ack = 1'($urandom);
      else             wb_ack = (k == last);
      drive_id(mode, k, rd);
      #1;
      chk("fu_start", 32'(fu_start), 32'(k == 1));
      chk("ready_busy", 32'(dispatch_ready), 32'd0);
      chk("wb_valid", 32'(wb_valid), 32'(k >= 2 + lat));
      chk("stall_busy", 32'(stall), 32'(model_stall(1'b1, 1'b1, rd)));
      if (k == 1) begin
        chk("fu_op", 32'(fu_op), 32'(op));
        chk("fu_a", fu_a, a);
        chk("fu_b", fu_b, b);
        chk("fu_c", fu_c, c);
      end
      if (k >= 2 + lat) begin
        chk("wb_rd", 32'(wb_rd), 32'(rd));
        chk("wb_data", wb_data, res);
      end
      tick();
    end
    wb_ack = 1'($urandom);
    id_slow = 1'b1; id_use = 3'b111; id_rs1 = rd; id_rs2 = rd; id_rs3 = rd;
    id_rd = rd; id_fp_write = 1'b1;
    #1;
    chk("ready_after", 32'(dispatch_ready), 32'd1);
    chk("wb_valid_after", 32'(wb_valid), 32'd0);
    chk("stall_after", 32'(stall), 32'd0);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    id_slow = 1'b1; id_use = 3'b111; id_fp_write = 1'b1;
    #1;
    chk("rst_fu_start", 32'(fu_start), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fu_a", fu_a, 32'd0);
    chk("rst_ready", 32'(dispatch_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // fdiv 4.0/2.0 with immediate grant
    run_op(3'd4, 5'd5, 32'h40800000, 32'h40000000, 32'h0, 32'h40000000, 0, 0);
    tick();

    // back-pressure on fmadd with a RAW-dependent instruction in ID
    run_op(3'd0, 5'd3, $urandom, $urandom, $urandom, $urandom, 4, 1);
    tick();

    // hazard selectivity against rd=7
    run_op(3'd1, 5'd7, $urandom, $urandom, $urandom, $urandom, 1, 2);
    tick();

    // asynchronous reset three cycles into an fsqrt
    dispatch_op = FSQRT; dispatch_rd = 5'd12;
    dispatch_a = 32'h41100000; dispatch_b = 32'h1234; dispatch_c = 32'h5678;
    dispatch_valid = 1'b1;
    tick();
    dispatch_valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    id_slow = 1'b1; id_use = 3'b111; id_rs1 = 5'd12; id_rd = 5'd12; id_fp_write = 1'b1;
    #1;
    chk("mid_rst_fu_start", 32'(fu_start), 32'd0);
    chk("mid_rst_fu_op", 32'(fu_op), 32'd0);
    chk("mid_rst_fu_a", fu_a, 32'd0);
    chk("mid_rst_fu_b", fu_b, 32'd0);
    chk("mid_rst_fu_c", fu_c, 32'd0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(dispatch_ready), 32'd1);
    chk("post_rst_stall", 32'(stall), 32'd0);
    tick();
    run_op(3'd0, 5'd12, $urandom, $urandom, $urandom, $urandom, 0, 0);
    tick();

    // minimum latency instance
    dispatch_op = FMADD; dispatch_rd = 5'd9;
    dispatch_a = 32'h3f800000; dispatch_b = 32'h40000000; dispatch_c = 32'h40400000;
    dispatch_valid_m = 1'b1;
    tick();
    dispatch_valid_m = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      fu_result = (k == 2) ? 32'h40a00000 : $urandom;
      #1;
      chk("min_fu_start", 32'(fu_start_m), 32'(k == 1));
      chk("min_wb_valid", 32'(wb_valid_m), 32'(k == 3));
      chk("min_ready", 32'(dispatch_ready_m), 32'd0);
      if (k == 3) begin
        chk("min_wb_rd", 32'(wb_rd_m), 32'd9);
        chk("min_wb_data", wb_data_m, 32'h40a00000);
      end
      tick();
    end
    #1;
    chk("min_ready_after", 32'(dispatch_ready_m), 32'd1);
    chk("min_wb_valid_after", 32'(wb_valid_m), 32'd0);
    tick();

    // reserved op codes behave like fdiv
    run_op(3'd6, 5'd20, $urandom, $urandom, $urandom, $urandom, 1, 0);
    tick();
    run_op(3'd7, 5'd21, $urandom, $urandom, $urandom, $urandom, 0, 0);

    // randomized traffic, back-to-back or with short idle gaps
    for (int i = 0; i < 30; i++) begin
      int gap;
      run_op(3'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        drive_id(0, 0, 5'($urandom));
        wb_ack = 1'($urandom);
        #1;
        chk("idle_ready", 32'(dispatch_ready), 32'd1);
        chk("idle_stall", 32'(stall), 32'(model_stall(1'b0, 1'b0, 5'd0)));
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
